bit_serial_alu_ctrl: RTL and testbench

//  Sequencer that drives one alu_1bit slice LSB-first over WIDTH cycles to

---
 rtl/bit_serial_alu_ctrl.sv | 97 +++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_ctrl.sv
// Sequencer for a single alu_1bit slice: walks WIDTH bits LSB-first, chains the
// carry between bits and assembles the WIDTH-bit result with carry/zero flags.
module bit_serial_alu_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [1:0]       slice_op,
    input  logic             slice_result,
    input  logic             slice_cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);
    localparam logic [1:0] OpSub = 2'b01;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state;
    logic [CntW-1:0]   cnt;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic              cin_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  result_next;

    assign result_next = {slice_result, result[WIDTH-1:1]};

    // Slice inputs are idle (zero) outside RUN; op stays at the last accepted op.
    assign slice_a   = (state == StRun) ? a_sh[0] : 1'b0;
    assign slice_b   = (state == StRun) ? b_sh[0] : 1'b0;
    assign slice_cin = (state == StRun) ? cin_q : 1'b0;
    assign slice_op  = op_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= StIdle;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            cin_q     <= 1'b0;
            op_q      <= 2'b00;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle, StDone: begin
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        op_q  <= op;
                        // SUB is a + ~b + 1, so the first carry-in is 1.
                        cin_q <= (op == OpSub);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= StRun;
                    end else begin
                        state <= StIdle;
                    end
                end
                StRun: begin
                    result <= result_next;
                    cin_q  <= slice_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (cnt == CntLast) begin
                        carry_out <= slice_cout;
                        zero      <= (result_next == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= StDone;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Bench for bit_serial_alu_ctrl with a behavioural 1-bit ALU slice; expected
// results are queued at issue time and checked by a monitor on each done pulse.
module tb_bit_serial_alu_ctrl;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             zero;
    logic             slice_a;
    logic             slice_b;
    logic             slice_cin;
    logic [1:0]       slice_op;
    logic             slice_result;
    logic             slice_cout;

    bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .op           (op),
        .a_in         (a_in),
        .b_in         (b_in),
        .busy         (busy),
        .done         (done),
        .result       (result),
        .carry_out    (carry_out),
        .zero         (zero),
        .slice_a      (slice_a),
        .slice_b      (slice_b),
        .slice_cin    (slice_cin),
        .slice_op     (slice_op),
        .slice_result (slice_result),
        .slice_cout   (slice_cout)
    );

    // 1-bit ALU slice: 00 ADD, 01 SUB (b inverted), 10 AND, 11 OR; logic ops give cout=0.
    logic sb;
    always_comb begin
        sb           = (slice_op == 2'b01) ? ~slice_b : slice_b;
        slice_result = 1'b0;
        slice_cout   = 1'b0;
        case (slice_op)
            2'b00, 2'b01: begin
                slice_result = slice_a ^ sb ^ slice_cin;
                slice_cout   = (slice_a & sb) | (slice_a & slice_cin) | (sb & slice_cin);
            end
            2'b10: slice_result = slice_a & slice_b;
            default: slice_result = slice_a | slice_b;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             z;
        int               c0;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected done=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_result"}, int'(result), int'(e.res));
                check({e.name, "_carry"}, int'(carry_out), int'(e.cout));
                check({e.name, "_zero"}, int'(zero), int'(e.z));
                check({e.name, "_latency"}, cyc - e.c0, WIDTH);
            end
        end
    end

    // Call at a negedge; returns just after the accepting edge with start dropped.
    task automatic issue(input string name, input logic [1:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic ec);
        exp_t e;
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        e.res  = er;
        e.cout = ec;
        e.z    = (er == 8'h00);
        e.c0   = cyc;
        e.name = name;
        exp_q.push_back(e);
        check({name, "_busy"}, int'(busy), 1);
    endtask

    // Leaves the bench at the negedge of the done cycle (or after a bounded wait).
    task automatic wait_done(input string name);
        int n = 0;
        @(negedge clk);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done_seen"}, int'(done), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_result"}, int'(result), 0);
        check({tag, "_carry"}, int'(carry_out), 0);
        check({tag, "_zero"}, int'(zero), 0);
        check({tag, "_slice_in"}, int'({slice_a, slice_b, slice_cin}), 0);
        check({tag, "_slice_op"}, int'(slice_op), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue("add_5a_3c", 2'b00, 8'h5A, 8'h3C, 8'h96, 1'b0);
        wait_done("add_5a_3c");
        @(negedge clk);
        issue("add_ff_01", 2'b00, 8'hFF, 8'h01, 8'h00, 1'b1);
        wait_done("add_ff_01");
        @(negedge clk);
        issue("sub_10_01", 2'b01, 8'h10, 8'h01, 8'h0F, 1'b1);
        wait_done("sub_10_01");
        @(negedge clk);
        issue("sub_01_02", 2'b01, 8'h01, 8'h02, 8'hFF, 1'b0);
        wait_done("sub_01_02");
        @(negedge clk);
        issue("and_f0_3c", 2'b10, 8'hF0, 8'h3C, 8'h30, 1'b0);
        wait_done("and_f0_3c");
        // Issued in the DONE cycle: must be accepted back-to-back.
        issue("or_f0_0f", 2'b11, 8'hF0, 8'h0F, 8'hFF, 1'b0);
        wait_done("or_f0_0f");
        @(negedge clk);
        check("idle_after_done_busy", int'(busy), 0);

        // Start re-pulsed mid-RUN with different operands must be ignored.
        issue("add_12_34", 2'b00, 8'h12, 8'h34, 8'h46, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = 2'b01;
        a_in  = 8'hFF;
        b_in  = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_busy", int'(busy), 1);
        wait_done("add_12_34");
        repeat (12) @(negedge clk);

        // Reset in the middle of RUN aborts without a done pulse.
        begin
            exp_t dummy;
            start = 1'b1;
            op    = 2'b00;
            a_in  = 8'h5A;
            b_in  = 8'h3C;
            @(posedge clk);
            #1;
            start = 1'b0;
            repeat (4) @(negedge clk);
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            check_idle_outputs("midrun_reset");
            @(negedge clk);
            rst_n = 1'b1;
            dummy.name = "";
        end
        repeat (12) @(negedge clk);
        check("abort_no_done_busy", int'(busy), 0);

        issue("add_01_01", 2'b00, 8'h01, 8'h01, 8'h02, 1'b0);
        wait_done("add_01_01");
        repeat (4) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
